// File: rtl/dzcpu_uop_sequencer_pkg.sv
// dzcpu micro-op definitions shared by the sequencer: field widths, flow-field
// codes, the JCB op code and the sequencer state encoding.
package dzcpu_uop_sequencer_pkg;

    localparam int UPC_W_C  = 8;
    localparam int FLOW_W_C = 4;
    localparam int OP_W_C   = 5;
    localparam int OPR_W_C  = 4;
    localparam int UOP_W_C  = FLOW_W_C + OP_W_C + OPR_W_C;

    typedef enum logic [FLOW_W_C-1:0] {
        FLOW_OP           = 4'd0,
        FLOW_INC          = 4'd1,
        FLOW_EOF          = 4'd2,
        FLOW_INC_EOF      = 4'd3,
        FLOW_EOF_FU       = 4'd4,
        FLOW_INC_EOF_FU   = 4'd5,
        FLOW_INC_EOF_Z    = 4'd6,
        FLOW_INC_EOF_NZ   = 4'd7,
        FLOW_UPDATE_FLAGS = 4'd8,
        FLOW_NOP          = 4'd9
    } flow_e;

    // Op that pulls the second opcode byte and re-enters decode through the CB LUT.
    localparam logic [OP_W_C-1:0] OP_JCB = 5'h1F;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2
    } state_e;

    typedef struct packed {
        logic pc_inc;
        logic flags_update;
        logic end_flow;
        logic cond_z;
        logic cond_nz;
    } flow_ctl_t;

endpackage

// File: rtl/dzcpu_uop_sequencer_field_decode.sv
// Flow-field decoder: turns the 4-bit flow code into PC/flag/end controls.
// Codes outside the defined set decode to all-zero, i.e. behave as plain OP.
module dzcpu_uop_sequencer_field_decode
    import dzcpu_uop_sequencer_pkg::*;
(
    input  logic [FLOW_W_C-1:0] flow_i,
    output flow_ctl_t           ctl_o
);

    always_comb begin
        ctl_o = '0;
        case (flow_e'(flow_i))
            FLOW_INC:          ctl_o.pc_inc = 1'b1;
            FLOW_UPDATE_FLAGS: ctl_o.flags_update = 1'b1;
            FLOW_EOF:          ctl_o.end_flow = 1'b1;
            FLOW_INC_EOF: begin
                ctl_o.pc_inc   = 1'b1;
                ctl_o.end_flow = 1'b1;
            end
            FLOW_EOF_FU: begin
                ctl_o.flags_update = 1'b1;
                ctl_o.end_flow     = 1'b1;
            end
            FLOW_INC_EOF_FU: begin
                ctl_o.pc_inc       = 1'b1;
                ctl_o.flags_update = 1'b1;
                ctl_o.end_flow     = 1'b1;
            end
            FLOW_INC_EOF_Z: begin
                ctl_o.pc_inc = 1'b1;
                ctl_o.cond_z = 1'b1;
            end
            FLOW_INC_EOF_NZ: begin
                ctl_o.pc_inc  = 1'b1;
                ctl_o.cond_nz = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dzcpu_uop_sequencer.sv
// dzcpu microcode sequencer: fetch opcode, resolve flow start via main/CB LUT,
// then walk the micro-op ROM one entry per cycle.
//   state     | meaning
//   ST_FETCH  | request opcode byte at PC, wait for iMemValid
//   ST_DECODE | load uPC from main or CB LUT result
//   ST_EXEC   | issue micro-op at uPC, interpret flow field
module dzcpu_uop_sequencer
    import dzcpu_uop_sequencer_pkg::*;
#(
    parameter int UPC_W  = UPC_W_C,
    parameter int UOP_W  = UOP_W_C,
    parameter int FLOW_W = FLOW_W_C,
    parameter int OP_W   = OP_W_C,
    parameter int OPR_W  = OPR_W_C
)(
    input  logic             iClock,
    input  logic             iReset,
    output logic             oFetch,
    input  logic             iMemValid,
    input  logic [7:0]       iMemData,
    output logic [7:0]       oMop,
    output logic             oCbSel,
    input  logic [7:0]       iFlowIdx,
    input  logic [7:0]       iCbFlowIdx,
    output logic [UPC_W-1:0] oUopAddr,
    input  logic [UOP_W-1:0] iUop,
    input  logic             iStall,
    input  logic             iFlagZ,
    output logic             oUopValid,
    output logic [OP_W-1:0]  oOp,
    output logic [OPR_W-1:0] oOperand,
    output logic             oPcInc,
    output logic             oFlagsUpdate,
    output logic             oUcodeErr
);

    state_e           state_q, state_d;
    logic [UPC_W-1:0] upc_q, upc_d;
    logic [7:0]       mop_q, mop_d;
    logic             cb_sel_q, cb_sel_d;
    logic             ucode_err_q, ucode_err_d;

    logic [FLOW_W-1:0] uop_flow;
    logic [OP_W-1:0]   uop_op;
    logic [OPR_W-1:0]  uop_opr;
    flow_ctl_t         flow_ctl;
    logic              is_jcb, exec_go, cond_taken, flow_done, upc_at_max;

    assign uop_flow = iUop[UOP_W-1 -: FLOW_W];
    assign uop_op   = iUop[OPR_W +: OP_W];
    assign uop_opr  = iUop[OPR_W-1:0];

    dzcpu_uop_sequencer_field_decode u_field_decode (
        .flow_i (uop_flow),
        .ctl_o  (flow_ctl)
    );

    // JCB without its CB byte on the bus is indistinguishable from a stall.
    assign is_jcb     = (uop_op == OP_JCB);
    assign exec_go    = iReset && (state_q == ST_EXEC) && !iStall && (!is_jcb || iMemValid);
    assign cond_taken = (flow_ctl.cond_z && iFlagZ) || (flow_ctl.cond_nz && !iFlagZ);
    assign flow_done  = flow_ctl.end_flow || cond_taken;
    assign upc_at_max = &upc_q;

    assign oFetch       = (state_q == ST_FETCH);
    assign oUopAddr     = upc_q;
    assign oMop         = mop_q;
    assign oCbSel       = cb_sel_q;
    assign oUcodeErr    = ucode_err_q;
    assign oUopValid    = exec_go && !is_jcb && !cond_taken;
    assign oPcInc       = exec_go && flow_ctl.pc_inc;
    assign oFlagsUpdate = exec_go && !is_jcb && flow_ctl.flags_update;
    assign oOp          = oUopValid ? uop_op : '0;
    assign oOperand     = oUopValid ? uop_opr : '0;

    always_comb begin
        state_d     = state_q;
        upc_d       = upc_q;
        mop_d       = mop_q;
        cb_sel_d    = cb_sel_q;
        ucode_err_d = ucode_err_q;
        unique case (state_q)
            ST_FETCH: begin
                if (iMemValid) begin
                    mop_d    = iMemData;
                    cb_sel_d = 1'b0;
                    state_d  = ST_DECODE;
                end
            end
            ST_DECODE: begin
                upc_d   = UPC_W'(cb_sel_q ? iCbFlowIdx : iFlowIdx);
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (exec_go) begin
                    if (is_jcb) begin
                        mop_d    = iMemData;
                        cb_sel_d = 1'b1;
                        state_d  = ST_DECODE;
                    end else if (flow_done) begin
                        state_d = ST_FETCH;
                    end else if (upc_at_max) begin
                        ucode_err_d = 1'b1;
                        state_d     = ST_FETCH;
                    end else begin
                        upc_d = upc_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge iClock) begin
        if (!iReset) begin
            state_q     <= ST_FETCH;
            upc_q       <= '0;
            mop_q       <= '0;
            cb_sel_q    <= 1'b0;
            ucode_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            upc_q       <= upc_d;
            mop_q       <= mop_d;
            cb_sel_q    <= cb_sel_d;
            ucode_err_q <= ucode_err_d;
        end
    end

endmodule

// File: doc/dzcpu_uop_sequencer.md
Name: dzcpu_uop_sequencer

Overview:
- Microcode sequencer for the dzcpu core. It consumes the opcode-to-flow LUTs and the 13-bit micro-op ROM.
- It fetches an opcode byte, resolves the start index through the main or CB LUT, then walks the ROM address (uPC) one micro-op per cycle.
- For each micro-op it issues the op/operand fields to the datapath and interprets the flow field (PC increment, end-of-flow, conditional end, flag update).
- It sits between the memory fetch port, the LUT/ROM pair and the register/ALU datapath.

Parameters:
- UPC_W, 8, micro-PC / ROM address width
- UOP_W, 13, micro-op width; must equal FLOW_W+OP_W+OPR_W
- FLOW_W, 4, flow-control field width, uop[12:9]
- OP_W, 5, operation field width, uop[8:4]
- OPR_W, 4, operand field width, uop[3:0]

Ports:
- iClock  in  1  core clock
- iReset  in  1  reset; synchronous, active-low
- oFetch  out  1  opcode fetch request at current PC
- iMemValid  in  1  iMemData valid this cycle
- iMemData  in  8  memory read byte
- oMop  out  8  latched opcode, drives main and CB LUT iMop
- oCbSel  out  1  0 = use iFlowIdx, 1 = use iCbFlowIdx
- iFlowIdx  in  8  main LUT result
- iCbFlowIdx  in  8  CB LUT result
- oUopAddr  out  UPC_W  ROM iAddr
- iUop  in  UOP_W  ROM oUop
- iStall  in  1  datapath busy; hold issue
- iFlagZ  in  1  Z flag
- oUopValid  out  1  op/operand valid, datapath executes this cycle
- oOp  out  OP_W  operation field
- oOperand  out  OPR_W  operand field
- oPcInc  out  1  increment PC this cycle
- oFlagsUpdate  out  1  latch ALU flags this cycle
- oUcodeErr  out  1  sticky: flow overran uPC max

Behaviour:
- Reset (iReset==0 at a clock edge):
  - state=FETCH, uPC=0, oMop=0, oCbSel=0, oUcodeErr=0.
  - All strobes (oUopValid, oPcInc, oFlagsUpdate) are 0.
  - Reset mid-flow aborts the flow; no further strobes are issued.
- State FETCH:
  - oFetch=1.
  - On iMemValid: oMop<=iMemData, oCbSel<=0, go to DECODE.
- State DECODE:
  - uPC <= (oCbSel ? iCbFlowIdx : iFlowIdx), then go to EXEC. An index of 0 is legal (generic 1-byte flow).
  - Latency: iMemValid cycle -> first oUopValid is 2 cycles later.
- State EXEC:
  - oUopAddr=uPC combinationally. Decode iUop fields.
  - If iStall=1: all strobes are 0 and uPC holds.
  - Otherwise oUopValid=1 (except for JCB), oOp/oOperand = fields. The flow field then acts as follows:
    - OP, NOP: uPC+1.
    - INC: oPcInc=1, uPC+1.
    - UPDATE_FLAGS: oFlagsUpdate=1, uPC+1.
    - EOF: go to FETCH.
    - INC_EOF: oPcInc=1, go to FETCH.
    - EOF_FU: oFlagsUpdate=1, go to FETCH.
    - INC_EOF_FU: oPcInc=1 and oFlagsUpdate=1, go to FETCH.
    - INC_EOF_Z: oPcInc=1. If iFlagZ=1, go to FETCH and force oUopValid=0. Otherwise issue the uop and take uPC+1.
    - INC_EOF_NZ: mirror of INC_EOF_Z on iFlagZ=0.
  - Op field == JCB:
    - oUopValid=0, flow field still honoured for oPcInc.
    - Requires iMemValid that cycle. Then oMop<=iMemData, oCbSel<=1, go to DECODE.
    - If iMemValid=0, treat as a stall.
- uPC overflow: a non-ending uop at uPC=2^UPC_W-1 sets oUcodeErr (sticky until reset) and returns to FETCH; uPC does not wrap.
- Unused flow codes behave as OP.
- Back-to-back: an EOF in cycle N gives oFetch=1 in cycle N+1. FETCH may complete in N+1 if iMemValid.

Decomposition:
- Shared package/include dzcpu_uop_defs (extends the existing opcode-definitions include):
  - flow-field encodings: OP=0, INC=1, EOF=2, INC_EOF=3, EOF_FU=4, INC_EOF_FU=5, INC_EOF_Z=6, INC_EOF_NZ=7, UPDATE_FLAGS=8, NOP=9
  - op code JCB
  - field width/position constants
  - state encoding
- One natural sub-module: dzcpu_uop_field_decode. It is purely combinational: flow field -> {pc_inc, flags_update, end, cond_z, cond_nz}.

Test Plan:
- One-byte op: fetch 0x00, iFlowIdx=0, iUop={INC_EOF,op,A} -> exactly one oUopValid with oPcInc=1. Then oFetch=1 the next cycle.
- LDSPnn-style flow: iFlowIdx=1, ROM 1..4 = INC, INC, OP, INC_EOF -> oUopAddr 1,2,3,4 on consecutive cycles, oPcInc pattern 1,1,0,1, then FETCH.
- Conditional JR (start 17, uop 19 = INC_EOF_Z):
  - iFlagZ=1: flow ends after 19 with no oUopValid at 19.
  - iFlagZ=0: addresses 19..22 are issued and the flow ends on the EOF at 22.
- CB map (start 13, uop 15 = INC+JCB, iMemData=0x7C, iCbFlowIdx=16):
  - oMop=0x7C, oCbSel=1, next EXEC at uPC=16.
  - EOF_FU at 16 gives oFlagsUpdate=1.
- Stall: iStall high 3 cycles at uPC=3 -> oUopAddr holds 3, no strobes; the flow resumes unchanged.
- Reset/overflow:
  - iReset=0 at uPC=5 mid-flow -> next cycle FETCH, all strobes 0.
  - Flow reaching uPC=255 with uop OP -> oUcodeErr=1, state FETCH.
